// File: rtl/bcd_down_timer_if.sv
// ---------------------------------------------------------------------------
// bcd_down_timer_if
// Control and status bundle for the BCD down-timer.
//   load        load load_value into count and reload register
//   load_value  BCD start value, digit 0 in bits [3:0]
//   start       begin / re-arm counting
//   T           count enable while running
//   Q           current BCD count
//   Q_bar       bitwise inverse of Q
//   busy        high while running
//   done        one-cycle pulse on the edge where the count reaches zero
// master = the controlling side, slave = the timer.
// ---------------------------------------------------------------------------
interface bcd_down_timer_if #(
    parameter int DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  start;
    logic                  T;
    logic [4*DIGITS-1:0]   Q;
    logic [4*DIGITS-1:0]   Q_bar;
    logic                  busy;
    logic                  done;

    modport master (
        output load, load_value, start, T,
        input  Q, Q_bar, busy, done
    );

    modport slave (
        input  load, load_value, start, T,
        output Q, Q_bar, busy, done
    );
endinterface

// File: rtl/bcd_down_timer.sv
// ---------------------------------------------------------------------------
// bcd_down_timer
// Cascadable BCD down-counter / interval timer. Loads a decimal start value,
// decrements once per enabled clock while running, and pulses done when the
// count reaches zero. With AUTO_RELOAD the count restarts from the reload
// register instead of stopping.
// Ports:
//   clock  rising-edge clock
//   clear  synchronous active-high reset (highest priority)
//   bus    bcd_down_timer_if.slave: load, load_value, start, T in;
//          Q, Q_bar, busy, done out (all registered)
// ---------------------------------------------------------------------------
module bcd_down_timer #(
    parameter int DIGITS      = 2,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic               clock,
    input  logic               clear,
    bcd_down_timer_if.slave    bus
);
    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ZERO = '0;
    localparam logic [W-1:0] ONE  = W'(1);

    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

    state_t         state;
    logic [W-1:0]   q;
    logic [W-1:0]   q_bar;
    logic [W-1:0]   reload;
    logic           busy;
    logic           done;
    logic [W-1:0]   load_san;
    logic [W-1:0]   dec_val;

    // Clamp every decade above 9 down to 9 so the count stays valid BCD.
    function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // One BCD decrement: the borrow ripples through the decades in a single
    // combinational pass, a zero digit wrapping to 9.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign load_san = sanitize(bus.load_value);
    assign dec_val  = bcd_dec(q);

    // Q_bar is kept as its own register so it is a true registered output.
    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= IDLE;
            q      <= '0;
            q_bar  <= '1;
            reload <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.load) begin
                // load wins over start/T in every state
                q      <= load_san;
                q_bar  <= ~load_san;
                reload <= load_san;
                state  <= IDLE;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && (q != ZERO)) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.T) begin
                            if (q == ONE) begin
                                done <= 1'b1;
                                if (AUTO_RELOAD && (reload != ZERO)) begin
                                    q     <= reload;
                                    q_bar <= ~reload;
                                end else begin
                                    q     <= '0;
                                    q_bar <= '1;
                                    state <= EXPIRED;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                q     <= dec_val;
                                q_bar <= ~dec_val;
                            end
                        end
                    end
                    EXPIRED: begin
                        if (bus.start && (reload != ZERO)) begin
                            q     <= reload;
                            q_bar <= ~reload;
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.Q     = q;
    assign bus.Q_bar = q_bar;
    assign bus.busy  = busy;
    assign bus.done  = done;

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Cascadable BCD down-counter: the counting-down companion to the team's mod-10 decade up-counter.
- Loads a decimal start value, then decrements one count per enabled clock.
- Borrows ripple across DIGITS decade stages; the block signals expiry when the count reaches zero.
- Sits beside the decade counter in the counter library and serves as a countdown/interval timer.

Parameters:
DIGITS, 2, number of cascaded BCD decades (1..8); Q width = 4*DIGITS.
AUTO_RELOAD, 0, 1 = on reaching zero reload from the reload register and keep running; 0 = stop in EXPIRED.

Ports:
clock  input  1  rising-edge clock, only clock domain.
clear  input  1  synchronous active-high reset.
load  input  1  load load_value into count and reload register.
load_value  input  4*DIGITS  BCD start value, digit 0 in bits [3:0].
start  input  1  begin/re-arm counting.
T  input  1  count enable; one decrement per cycle while high in RUN.
Q  output  4*DIGITS  current BCD count.
Q_bar  output  4*DIGITS  bitwise inverse of Q.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse on the clock edge where the count reaches zero.

Behaviour:
- Reset: on a rising edge with clear=1, Q=0, Q_bar=all ones, reload register=0, state=IDLE, busy=0, done=0. clear has priority over every other input.
- All outputs are registered; Q_bar always equals ~Q.
- Input sanitising: any load_value digit >9 is clamped to 9 before storing (e.g. nibble 4'hC stores as 4'h9).
- States: IDLE, RUN, EXPIRED.
- Priority within a cycle: clear > load > start > T.
- load (any state): Q and reload register take the sanitised value; state goes to IDLE; done=0. A start in the same cycle is ignored.
- IDLE + start:
  - Q!=0: go to RUN next cycle. No decrement occurs in the start cycle.
  - Q==0: start is ignored; state stays IDLE.
- RUN, T=0: hold Q (pause).
- RUN, T=1: BCD decrement.
  - Digit 0 decrements. A digit at 0 wraps to 9 and borrows from the next digit.
  - Borrow ripples combinationally within the same cycle; there is no intermediate binary value.
- Reaching zero (RUN, T=1, Q==1):
  - AUTO_RELOAD=0: Q becomes 0, done=1 for one cycle, state goes to EXPIRED, busy=0.
  - AUTO_RELOAD=1: Q becomes the reload register, done=1 for one cycle, state stays RUN. Q never shows 0 in this mode.
  - If the reload register is 0, the block goes to EXPIRED.
- EXPIRED: Q holds 0.
  - start: Q takes the reload register and state goes to RUN when reload!=0; otherwise start is ignored.
  - load behaves as in any state.
- start while in RUN is ignored.
- done is asserted only on an expiry edge and only for one cycle; it never asserts in IDLE.
- Latency: load to Q = 1 cycle. start to first decrement = 2 edges (start edge, then first T edge in RUN).
- clear mid-RUN: the next edge gives the full reset state and the reload register is lost.

Test Plan:
- Reset: clear=1 for 2 cycles with load=1, start=1, T=1 held -> Q=0x00, Q_bar=0xFF, busy=0, done=0.
- Load/borrow: load 0x21, start, T=1 continuous -> Q sequence 21,20,19,18…01,00; done pulses exactly once, on the 00 edge; state is EXPIRED and Q holds 00 for 10 more cycles.
- Pause and clamp: load 0x3C (stores 0x39), start, toggle T 1,0,0,1 -> Q 39,38,38,38,37; busy=1 throughout.
- Auto-reload: AUTO_RELOAD=1, DIGITS=1, load 3, start, T=1 for 9 cycles -> Q 3,2,1,3,2,1,3,2,1; done pulses on every 1->3 transition; Q never shows 0.
- Priority and edges: load=1 with start=1 -> IDLE, no decrement. start with Q=0 -> stays IDLE. start in EXPIRED after load 0x05 -> Q=05, busy=1.
- Mid-run reset: clear pulsed while Q=0x14 in RUN -> next edge Q=0, IDLE. A following start is ignored (Q=0, reload=0).
